// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main control unit.
// ctrl_of() is the Moore output table: one control word per FSM state.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [1:0] ALUSRCB_B    = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM  = 2'b10;
  localparam logic [1:0] ALUSRCB_SHL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       branch;
    logic       pcwrite;
  } ctrl_t;

  function automatic ctrl_t ctrl_of(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.irwrite = 1'b1;
        c.alusrcb = ALUSRCB_FOUR;
        c.pcwrite = 1'b1;
      end
      S_DECODE:  c.alusrcb = ALUSRCB_SHL2;
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = ALUSRCB_IMM;
      end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BEQEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.branch  = 1'b1;
        c.pcsrc   = PCSRC_ALUOUT;
      end
      S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = ALUSRCB_IMM;
      end
      S_ADDIWB:  c.regwrite = 1'b1;
      S_JEX: begin
        c.pcsrc   = PCSRC_JUMP;
        c.pcwrite = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// ALU decoder: maps aluop and the R-type funct field to a 3-bit ALU operation.
module alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [1:0]     aluop,
  input  logic [OPW-1:0] funct,
  output logic [2:0]     alucontrol
);

  always_comb begin
    alucontrol = ALUC_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALUC_ADD;
          F_SUB:   alucontrol = ALUC_SUB;
          F_AND:   alucontrol = ALUC_AND;
          F_OR:    alucontrol = ALUC_OR;
          F_SLT:   alucontrol = ALUC_SLT;
          default: alucontrol = ALUC_ADD;
        endcase
      end
      default: alucontrol = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath (Moore, registered control word).
//
// state   | meaning
// FETCH   | read instr at PC into IR, PC <= PC+4
// DECODE  | read regs, precompute branch target into ALUOut
// MEMADR  | ALUOut <= A + signimm
// MEMRD   | read data memory at ALUOut
// MEMWB   | rt <= Data
// MEMWR   | write B to memory at ALUOut
// RTYPEEX | ALUOut <= A op B
// RTYPEWB | rd <= ALUOut
// BEQEX   | compare A-B, PC <= ALUOut if zero
// ADDIEX  | ALUOut <= A + signimm
// ADDIWB  | rt <= ALUOut
// JEX     | PC <= jump target
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPW          = 6,
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] op,
  input  logic [OPW-1:0] funct,
  input  logic           zero,
  output logic           pcen,
  output logic           iord,
  output logic           memwrite,
  output logic           irwrite,
  output logic           regdst,
  output logic           memtoreg,
  output logic           regwrite,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic [2:0]     alucontrol,
  output logic           illegal_op,
  output logic [3:0]     state_dbg
);

  state_t state, state_n;
  ctrl_t  ctrl_q, cs;
  logic   is_store;
  logic   known_op;

  always_comb begin
    state_n  = S_FETCH;
    known_op = 1'b1;
    case (state)
      S_FETCH: state_n = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_RTYPE:     state_n = S_RTYPEEX;
          OP_BEQ:       state_n = S_BEQEX;
          OP_ADDI:      state_n = S_ADDIEX;
          OP_J:         state_n = S_JEX;
          default: begin
            state_n  = S_FETCH;
            known_op = 1'b0;
          end
        endcase
      end
      // lw/sw choice is latched in DECODE so later op changes cannot redirect it
      S_MEMADR:  state_n = is_store ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_n = S_MEMWB;
      S_RTYPEEX: state_n = S_RTYPEWB;
      S_ADDIEX:  state_n = S_ADDIWB;
      default:   state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_FETCH;
      ctrl_q   <= ctrl_of(S_FETCH);
      is_store <= 1'b0;
    end else begin
      state  <= state_n;
      ctrl_q <= ctrl_of(state_n);
      if (state == S_DECODE)
        is_store <= (op == OP_SW);
    end
  end

  // While reset is held the control word shows FETCH and every write enable is blocked.
  assign cs = rst ? ctrl_q : ctrl_of(S_FETCH);

  assign pcen       = rst & (cs.pcwrite | (cs.branch & zero));
  assign irwrite    = rst & cs.irwrite;
  assign regwrite   = rst & cs.regwrite;
  assign memwrite   = rst & cs.memwrite;
  assign iord       = cs.iord;
  assign regdst     = cs.regdst;
  assign memtoreg   = cs.memtoreg;
  assign alusrca    = cs.alusrca;
  assign alusrcb    = cs.alusrcb;
  assign pcsrc      = cs.pcsrc;
  assign illegal_op = rst & (ILLEGAL_TRAP != 0) & (state == S_DECODE) & ~known_op;
  assign state_dbg  = rst ? state : S_FETCH;

  alu_decoder #(.OPW(OPW)) u_alu_decoder (
    .aluop      (cs.aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class and checks
// state sequence and control outputs against hand-computed values.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal_op;
  logic [3:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  mips_multicycle_ctrl #(.OPW(6), .ILLEGAL_TRAP(1)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; op = 6'b100011; funct = 6'b0; zero = 1'b0;
    tick(); tick();
    n_cmp++; if (state_dbg !== 4'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    n_cmp++; if (pcen !== 1'b0) begin n_err++; $display("FAIL reset_pcen got=%b exp=0", pcen); end
    n_cmp++; if (irwrite !== 1'b0) begin n_err++; $display("FAIL reset_irwrite got=%b exp=0", irwrite); end
    n_cmp++; if (alusrcb !== 2'b01) begin n_err++; $display("FAIL reset_alusrcb got=%b exp=01", alusrcb); end
    rst = 1'b1;
    #1;
    n_cmp++; if (irwrite !== 1'b1 || pcen !== 1'b1) begin n_err++; $display("FAIL fetch_after_reset irwrite=%b pcen=%b exp=1/1", irwrite, pcen); end
  endtask

  task automatic test_lw();
    logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    op = 6'b100011;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (state_dbg !== exp_s[i]) begin n_err++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, state_dbg, exp_s[i]); end
      n_cmp++; if (regwrite !== (i == 4) || memtoreg !== (i == 4)) begin n_err++; $display("FAIL lw_wb[%0d] regwrite=%b memtoreg=%b exp=%b", i, regwrite, memtoreg, (i == 4)); end
      n_cmp++; if (iord !== (i == 3)) begin n_err++; $display("FAIL lw_iord[%0d] got=%b exp=%b", i, iord, (i == 3)); end
      tick();
    end
    n_cmp++; if (state_dbg !== 4'd0) begin n_err++; $display("FAIL lw_end got=%0d exp=0", state_dbg); end
  endtask

  task automatic test_sw();
    logic [3:0] exp_s [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
    op = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (state_dbg !== exp_s[i]) begin n_err++; $display("FAIL sw_state[%0d] got=%0d exp=%0d", i, state_dbg, exp_s[i]); end
      n_cmp++; if (memwrite !== (i == 3) || iord !== (i == 3)) begin n_err++; $display("FAIL sw_mem[%0d] memwrite=%b iord=%b exp=%b", i, memwrite, iord, (i == 3)); end
      n_cmp++; if (regwrite !== 1'b0) begin n_err++; $display("FAIL sw_regwrite[%0d] got=%b exp=0", i, regwrite); end
      if (i == 2) op = 6'b100011;  // must not redirect the store once decoded
      tick();
    end
    n_cmp++; if (state_dbg !== 4'd0) begin n_err++; $display("FAIL sw_end got=%0d exp=0", state_dbg); end
  endtask

  task automatic test_rtype();
    logic [5:0] fn [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    logic [2:0] ac [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
    logic [3:0] exp_s [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
    for (int k = 0; k < 6; k++) begin
      op = 6'b000000; funct = fn[k];
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (state_dbg !== exp_s[i]) begin n_err++; $display("FAIL rtype_state[%0d][%0d] got=%0d exp=%0d", k, i, state_dbg, exp_s[i]); end
        if (i == 0) begin
          n_cmp++; if (alucontrol !== 3'b010) begin n_err++; $display("FAIL rtype_fetch_alu[%0d] got=%b exp=010", k, alucontrol); end
        end
        if (i == 2) begin
          n_cmp++; if (alucontrol !== ac[k]) begin n_err++; $display("FAIL rtype_alu[%0d] got=%b exp=%b", k, alucontrol, ac[k]); end
          n_cmp++; if (alusrca !== 1'b1 || alusrcb !== 2'b00) begin n_err++; $display("FAIL rtype_src[%0d] a=%b b=%b exp=1/00", k, alusrca, alusrcb); end
        end
        if (i == 3) begin
          n_cmp++; if (regdst !== 1'b1 || regwrite !== 1'b1 || memtoreg !== 1'b0) begin n_err++; $display("FAIL rtype_wb[%0d] regdst=%b regwrite=%b memtoreg=%b exp=1/1/0", k, regdst, regwrite, memtoreg); end
        end
        tick();
      end
    end
  endtask

  task automatic test_beq();
    logic [3:0] exp_s [3] = '{4'd0, 4'd1, 4'd8};
    logic       zv [2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      op = 6'b000100; zero = zv[k];
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (state_dbg !== exp_s[i]) begin n_err++; $display("FAIL beq_state[%0d][%0d] got=%0d exp=%0d", k, i, state_dbg, exp_s[i]); end
        if (i == 1) begin
          n_cmp++; if (alusrcb !== 2'b11 || pcen !== 1'b0) begin n_err++; $display("FAIL beq_decode[%0d] alusrcb=%b pcen=%b exp=11/0", k, alusrcb, pcen); end
        end
        if (i == 2) begin
          n_cmp++; if (pcsrc !== 2'b01 || pcen !== zv[k]) begin n_err++; $display("FAIL beq_ex[%0d] pcsrc=%b pcen=%b exp=01/%b", k, pcsrc, pcen, zv[k]); end
          n_cmp++; if (alucontrol !== 3'b110) begin n_err++; $display("FAIL beq_alu[%0d] got=%b exp=110", k, alucontrol); end
        end
        tick();
      end
      n_cmp++; if (state_dbg !== 4'd0) begin n_err++; $display("FAIL beq_end[%0d] got=%0d exp=0", k, state_dbg); end
    end
    zero = 1'b0;
  endtask

  task automatic test_addi_j();
    logic [3:0] exp_a [4] = '{4'd0, 4'd1, 4'd9, 4'd10};
    logic [3:0] exp_j [3] = '{4'd0, 4'd1, 4'd11};
    op = 6'b001000;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (state_dbg !== exp_a[i]) begin n_err++; $display("FAIL addi_state[%0d] got=%0d exp=%0d", i, state_dbg, exp_a[i]); end
      if (i == 2) begin
        n_cmp++; if (alusrcb !== 2'b10 || alusrca !== 1'b1) begin n_err++; $display("FAIL addi_ex alusrcb=%b alusrca=%b exp=10/1", alusrcb, alusrca); end
      end
      if (i == 3) begin
        n_cmp++; if (regdst !== 1'b0 || regwrite !== 1'b1 || memtoreg !== 1'b0) begin n_err++; $display("FAIL addi_wb regdst=%b regwrite=%b memtoreg=%b exp=0/1/0", regdst, regwrite, memtoreg); end
      end
      tick();
    end
    op = 6'b000010;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (state_dbg !== exp_j[i]) begin n_err++; $display("FAIL j_state[%0d] got=%0d exp=%0d", i, state_dbg, exp_j[i]); end
      if (i == 2) begin
        n_cmp++; if (pcsrc !== 2'b10 || pcen !== 1'b1) begin n_err++; $display("FAIL j_ex pcsrc=%b pcen=%b exp=10/1", pcsrc, pcen); end
      end
      tick();
    end
    n_cmp++; if (state_dbg !== 4'd0) begin n_err++; $display("FAIL j_end got=%0d exp=0", state_dbg); end
  endtask

  task automatic test_illegal();
    op = 6'b111111;
    n_cmp++; if (illegal_op !== 1'b0) begin n_err++; $display("FAIL illegal_fetch got=%b exp=0", illegal_op); end
    tick();
    n_cmp++; if (state_dbg !== 4'd1 || illegal_op !== 1'b1) begin n_err++; $display("FAIL illegal_decode state=%0d illegal_op=%b exp=1/1", state_dbg, illegal_op); end
    tick();
    n_cmp++; if (state_dbg !== 4'd0 || illegal_op !== 1'b0) begin n_err++; $display("FAIL illegal_next state=%0d illegal_op=%b exp=0/0", state_dbg, illegal_op); end
  endtask

  task automatic test_reset_midinstr();
    op = 6'b100011;
    tick(); tick(); tick();
    n_cmp++; if (state_dbg !== 4'd3) begin n_err++; $display("FAIL mid_memrd got=%0d exp=3", state_dbg); end
    rst = 1'b0;
    #1;
    n_cmp++; if (regwrite !== 1'b0 || state_dbg !== 4'd0) begin n_err++; $display("FAIL mid_rst_comb regwrite=%b state=%0d exp=0/0", regwrite, state_dbg); end
    tick();
    n_cmp++; if (regwrite !== 1'b0 || memtoreg !== 1'b0) begin n_err++; $display("FAIL mid_rst_edge regwrite=%b memtoreg=%b exp=0/0", regwrite, memtoreg); end
    rst = 1'b1;
    #1;
    n_cmp++; if (state_dbg !== 4'd0 || regwrite !== 1'b0 || irwrite !== 1'b1) begin n_err++; $display("FAIL mid_release state=%0d regwrite=%b irwrite=%b exp=0/0/1", state_dbg, regwrite, irwrite); end
    tick();
    n_cmp++; if (state_dbg !== 4'd1) begin n_err++; $display("FAIL mid_restart got=%0d exp=1", state_dbg); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_beq();
    test_addi_j();
    test_illegal();
    test_reset_midinstr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
